regfile_operand_fetch: RTL and testbench

- Initiator side of the 2-read/2-write register file port set.
- Accepts one decoded instruction at a time; issues up to two source reads; captures operands; presents them to the execute stage over a valid/ready handshake.
- Forwards two writeback channels to the register-file write ports.
- Keeps a per-register pending scoreboard so read-after-write (RAW) and write-after-write (WAW) hazards stall issue.

---
 rtl/regfile_operand_fetch.sv | 242 ++++++++++++++++++++++++
 tb/tb_regfile_operand_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_fetch.sv
// ---------------------------------------------------------------------------
// regfile_operand_fetch
//
// Purpose:
//   Operand-fetch stage that sits on the initiator side of a 2-read/2-write
//   register file. It accepts one decoded instruction at a time, issues up to
//   two source reads, captures the returned operands and offers them to the
//   execute stage over a valid/ready handshake. Two writeback channels are
//   forwarded straight to the register-file write ports. A per-register
//   pending scoreboard stalls issue on RAW and WAW hazards.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, a pending source that matches a
//   same-cycle writeback is not a hazard. The writeback data is captured at
//   accept and used in place of the register-file read data. When both
//   channels match, channel 1 wins.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      instruction handshake (in_ready is combinational)
//   in_rs0/in_rs1/in_use   source addresses and their used flags
//   in_rd/in_rd_we         destination register and its write flag
//   op_valid/op_ready      operand handshake toward execute
//   op_a/op_b              operand values, 0 for an unused source
//   op_rd/op_rd_we         destination passed through to execute
//   wb_valid/wb_addr*/wb_data*  writeback channels 0 and 1
//   rf_ra*/rf_read/rf_rd*  register-file read ports (data one cycle later)
//   rf_wa*/rf_wd*/rf_write register-file write ports
// ---------------------------------------------------------------------------
module regfile_operand_fetch #(
    parameter int addrsize = 5,
    parameter int regsnum  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [addrsize-1:0] in_rs0,
    input  logic [addrsize-1:0] in_rs1,
    input  logic [1:0]          in_use,
    input  logic [addrsize-1:0] in_rd,
    input  logic                in_rd_we,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [31:0]         op_a,
    output logic [31:0]         op_b,
    output logic [addrsize-1:0] op_rd,
    output logic                op_rd_we,
    input  logic [1:0]          wb_valid,
    input  logic [addrsize-1:0] wb_addr0,
    input  logic [addrsize-1:0] wb_addr1,
    input  logic [31:0]         wb_data0,
    input  logic [31:0]         wb_data1,
    output logic [addrsize-1:0] rf_ra0,
    output logic [addrsize-1:0] rf_ra1,
    output logic [1:0]          rf_read,
    input  logic [31:0]         rf_rd0,
    input  logic [31:0]         rf_rd1,
    output logic [addrsize-1:0] rf_wa0,
    output logic [addrsize-1:0] rf_wa1,
    output logic [31:0]         rf_wd0,
    output logic [31:0]         rf_wd1,
    output logic [1:0]          rf_write
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [regsnum-1:0]  pend_q, pend_d;
    logic [1:0]          use_q;
    logic [addrsize-1:0] rd_q;
    logic                rdWe_q;
    logic [31:0]         opA_q, opB_q;

    logic                src0Haz, src1Haz, rdHaz, hazard;
    logic                slotFree, accept;
    logic [31:0]         src0Val, src1Val;

`ifdef REGFILE_BYPASS_EN
    logic                src0Hit, src1Hit;
    logic [31:0]         src0Fwd, src1Fwd;
    logic [1:0]          bypHit_q;
    logic [31:0]         bypData0_q, bypData1_q;

    // A source matching a live writeback channel can take that data directly.
    // Channel 1 is checked last so it wins when both channels match, which
    // mirrors what the register file itself ends up storing.
    always_comb begin
        src0Hit = 1'b0;
        src0Fwd = 32'd0;
        src1Hit = 1'b0;
        src1Fwd = 32'd0;
        if (wb_valid[0] && (wb_addr0 == in_rs0)) begin
            src0Hit = 1'b1;
            src0Fwd = wb_data0;
        end
        if (wb_valid[1] && (wb_addr1 == in_rs0)) begin
            src0Hit = 1'b1;
            src0Fwd = wb_data1;
        end
        if (wb_valid[0] && (wb_addr0 == in_rs1)) begin
            src1Hit = 1'b1;
            src1Fwd = wb_data0;
        end
        if (wb_valid[1] && (wb_addr1 == in_rs1)) begin
            src1Hit = 1'b1;
            src1Fwd = wb_data1;
        end
    end

    assign src0Haz = in_use[0] & pend_q[in_rs0] & ~src0Hit;
    assign src1Haz = in_use[1] & pend_q[in_rs1] & ~src1Hit;

    // Forwarded data is captured at accept, because the writeback is gone by
    // the time the READ cycle comes around.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bypHit_q   <= 2'b00;
            bypData0_q <= 32'd0;
            bypData1_q <= 32'd0;
        end else if (accept) begin
            bypHit_q   <= {src1Hit, src0Hit};
            bypData0_q <= src0Fwd;
            bypData1_q <= src1Fwd;
        end
    end

    assign src0Val = bypHit_q[0] ? bypData0_q : rf_rd0;
    assign src1Val = bypHit_q[1] ? bypData1_q : rf_rd1;
`else
    assign src0Haz = in_use[0] & pend_q[in_rs0];
    assign src1Haz = in_use[1] & pend_q[in_rs1];
    assign src0Val = rf_rd0;
    assign src1Val = rf_rd1;
`endif

    // The destination check guards WAW: a second writer to a pending
    // register would let the older writeback clear the newer pend bit.
    assign rdHaz  = in_rd_we & pend_q[in_rd];
    assign hazard = src0Haz | src1Haz | rdHaz;

    // A new instruction fits when the stage is empty or the held operands
    // are leaving this very cycle. rst gates it so nothing issues in reset.
    assign slotFree = (state_q == IDLE) || ((state_q == HOLD) && op_ready);
    assign in_ready = rst & ~hazard & slotFree;
    assign accept   = in_valid & in_ready;

    // Reads are launched in the accept cycle so the registered data lines up
    // with the READ state one cycle later.
    assign rf_ra0  = in_rs0;
    assign rf_ra1  = in_rs1;
    assign rf_read = accept ? in_use : 2'b00;

    // Writeback pass-through; suppressed while reset is held.
    assign rf_wa0   = wb_addr0;
    assign rf_wa1   = wb_addr1;
    assign rf_wd0   = wb_data0;
    assign rf_wd1   = wb_data1;
    assign rf_write = rst ? wb_valid : 2'b00;

    // Next-state logic for the IDLE -> READ -> HOLD handshake loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (op_ready) begin
                    state_d = accept ? READ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scoreboard next value. Clears are applied before the set so that a
    // fresh writer always leaves its destination marked pending.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid[0]) begin
            pend_d[wb_addr0] = 1'b0;
        end
        if (wb_valid[1]) begin
            pend_d[wb_addr1] = 1'b0;
        end
        if (accept && in_rd_we) begin
            pend_d[in_rd] = 1'b1;
        end
    end

    // State and scoreboard registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Instruction fields are latched at accept; the operands are captured in
    // READ and then held untouched for the whole HOLD period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            use_q  <= 2'b00;
            rd_q   <= '0;
            rdWe_q <= 1'b0;
            opA_q  <= 32'd0;
            opB_q  <= 32'd0;
        end else begin
            if (accept) begin
                use_q  <= in_use;
                rd_q   <= in_rd;
                rdWe_q <= in_rd_we;
            end
            if (state_q == READ) begin
                opA_q <= use_q[0] ? src0Val : 32'd0;
                opB_q <= use_q[1] ? src1Val : 32'd0;
            end
        end
    end

    assign op_valid = (state_q == HOLD);
    assign op_a     = opA_q;
    assign op_b     = opB_q;
    assign op_rd    = rd_q;
    assign op_rd_we = rdWe_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_regfile_operand_fetch
//
// Self-checking bench for regfile_operand_fetch. A small register-file model
// answers the DUT's read and write ports. Expected operands come from a
// separate array that tracks what each register should hold, plus a pending
// set, both updated from the stimulus the bench itself drives.
// Honours REGFILE_BYPASS_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_regfile_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs0, in_rs1, in_rd;
    logic [1:0]  in_use;
    logic        in_rd_we;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic        op_rd_we;
    logic [1:0]  wb_valid;
    logic [4:0]  wb_addr0, wb_addr1;
    logic [31:0] wb_data0, wb_data1;
    logic [4:0]  rf_ra0, rf_ra1, rf_wa0, rf_wa1;
    logic [1:0]  rf_read, rf_write;
    logic [31:0] rf_rd0, rf_rd1, rf_wd0, rf_wd1;

    logic [31:0] rfMem [32];
    logic [31:0] refMem [32];
    bit          refPend [32];
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] holdA, holdB;

    regfile_operand_fetch #(.addrsize(5), .regsnum(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs0(in_rs0), .in_rs1(in_rs1), .in_use(in_use),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_we(op_rd_we),
        .wb_valid(wb_valid), .wb_addr0(wb_addr0), .wb_addr1(wb_addr1),
        .wb_data0(wb_data0), .wb_data1(wb_data1),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_read(rf_read),
        .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
        .rf_wa0(rf_wa0), .rf_wa1(rf_wa1), .rf_wd0(rf_wd0), .rf_wd1(rf_wd1),
        .rf_write(rf_write)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: registered reads return the value held before
    // this edge's writes; channel 1 lands last on a shared address.
    always @(posedge clk) begin
        if (rf_write[0]) rfMem[rf_wa0] <= rf_wd0;
        if (rf_write[1]) rfMem[rf_wa1] <= rf_wd1;
        if (rf_read[0])  rf_rd0 <= rfMem[rf_ra0];
        if (rf_read[1])  rf_rd1 <= rfMem[rf_ra1];
    end

    // Hard stop in case something wedges the sequence below.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: got %h required %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] useMask,
                                 input logic [4:0] rd, input logic we);
        in_valid = 1'b1;
        in_rs0   = rs0;
        in_rs1   = rs1;
        in_use   = useMask;
        in_rd    = rd;
        in_rd_we = we;
    endtask

    // One writeback cycle on both channels; the reference array is updated
    // in channel order so channel 1 wins on a shared address.
    task automatic writeback(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                             input logic [4:0] a1, input logic [31:0] d1);
        wb_valid = v;
        wb_addr0 = a0;
        wb_data0 = d0;
        wb_addr1 = a1;
        wb_data1 = d1;
        @(negedge clk);
        checkOutput("rf_write", {30'd0, rf_write}, {30'd0, v});
        if (v[0]) checkOutput("rf_wd0", rf_wd0, d0);
        if (v[1]) checkOutput("rf_wa1", {27'd0, rf_wa1}, {27'd0, a1});
        tick();
        wb_valid = 2'b00;
        if (v[0]) begin
            refMem[a0]  = d0;
            refPend[a0] = 1'b0;
        end
        if (v[1]) begin
            refMem[a1]  = d1;
            refPend[a1] = 1'b0;
        end
    endtask

    // Called just after the accepting edge: expects one READ cycle, then the
    // operands, then consumes them.
    task automatic finishOp(input logic [31:0] expA, input logic [31:0] expB,
                            input logic [4:0] expRd, input logic expWe);
        @(negedge clk);
        checkOutput("op_valid_read", {31'd0, op_valid}, 32'd0);
        checkOutput("rf_read_idle", {30'd0, rf_read}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("op_valid_hold", {31'd0, op_valid}, 32'd1);
        checkOutput("op_a", op_a, expA);
        checkOutput("op_b", op_b, expB);
        checkOutput("op_rd", {27'd0, op_rd}, {27'd0, expRd});
        checkOutput("op_rd_we", {31'd0, op_rd_we}, {31'd0, expWe});
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    // Offer one instruction from IDLE for a single cycle. The expected stall
    // decision and operands come from the reference arrays.
    task automatic runIssue(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] useMask,
                            input logic [4:0] rd, input logic we);
        logic        haz;
        logic [31:0] expA, expB;
        haz  = (useMask[0] && refPend[rs0]) || (useMask[1] && refPend[rs1]) || (we && refPend[rd]);
        expA = useMask[0] ? refMem[rs0] : 32'd0;
        expB = useMask[1] ? refMem[rs1] : 32'd0;
        applyStimulus(rs0, rs1, useMask, rd, we);
        @(negedge clk);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, ~haz});
        if (!haz) checkOutput("rf_read", {30'd0, rf_read}, {30'd0, useMask});
        tick();
        in_valid = 1'b0;
        if (!haz) begin
            if (we) refPend[rd] = 1'b1;
            finishOp(expA, expB, rd, we);
        end
    endtask

    function automatic logic [4:0] pickAddr();
        int start;
        start = $urandom_range(0, 31);
        for (int i = 0; i < 32; i++) begin
            if (refPend[(start + i) % 32]) return 5'((start + i) % 32);
        end
        return 5'(start);
    endfunction

    initial begin
        rst = 1'b0; in_valid = 1'b0; op_ready = 1'b0;
        in_rs0 = '0; in_rs1 = '0; in_use = '0; in_rd = '0; in_rd_we = 1'b0;
        wb_valid = 2'b11; wb_addr0 = 5'd1; wb_addr1 = 5'd2;
        wb_data0 = 32'hDEAD; wb_data1 = 32'hBEEF;

        // Reset state, with writebacks driven that must be ignored.
        #3;
        checkOutput("rst_op_valid", {31'd0, op_valid}, 32'd0);
        checkOutput("rst_op_a", op_a, 32'd0);
        checkOutput("rst_op_b", op_b, 32'd0);
        checkOutput("rst_op_rd", {27'd0, op_rd}, 32'd0);
        checkOutput("rst_op_rd_we", {31'd0, op_rd_we}, 32'd0);
        checkOutput("rst_rf_read", {30'd0, rf_read}, 32'd0);
        checkOutput("rst_rf_write", {30'd0, rf_write}, 32'd0);
        tick();
        wb_valid = 2'b00;
        rst = 1'b1;
        tick();

        // Give every register a known value, then the directed ones.
        for (int i = 0; i < 16; i++) begin
            writeback(2'b11, 5'(2 * i), $urandom, 5'(2 * i + 1), $urandom);
        end
        writeback(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);

        // Basic issue with both sources; latency T+2.
        runIssue(5'd3, 5'd4, 2'b11, 5'd0, 1'b0);

        // RAW stall on r5 until its writeback arrives.
        runIssue(5'd0, 5'd0, 2'b00, 5'd5, 1'b1);
        applyStimulus(5'd5, 5'd0, 2'b01, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("raw_stall", {31'd0, in_ready}, 32'd0);
            tick();
        end
        wb_valid = 2'b01; wb_addr0 = 5'd5; wb_data0 = 32'hABCD;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        checkOutput("raw_wb_cycle", {31'd0, in_ready}, 32'd1);
        tick();
        wb_valid = 2'b00;
`else
        checkOutput("raw_wb_cycle", {31'd0, in_ready}, 32'd0);
        tick();
        wb_valid = 2'b00;
        @(negedge clk);
        checkOutput("raw_after_wb", {31'd0, in_ready}, 32'd1);
        tick();
`endif
        refMem[5] = 32'hABCD;
        refPend[5] = 1'b0;
        in_valid = 1'b0;
        finishOp(32'hABCD, 32'd0, 5'd0, 1'b0);

        // HOLD back-pressure for five cycles, then a back-to-back issue.
        holdA = refMem[3];
        holdB = refMem[4];
        applyStimulus(5'd3, 5'd4, 2'b11, 5'd6, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        applyStimulus(5'd4, 5'd0, 2'b01, 5'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, op_valid}, 32'd1);
            checkOutput("hold_op_a", op_a, holdA);
            checkOutput("hold_op_b", op_b, holdB);
            checkOutput("hold_op_rd", {27'd0, op_rd}, 32'd6);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        op_ready = 1'b1;
        @(negedge clk);
        checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        op_ready = 1'b0;
        in_valid = 1'b0;
        finishOp(holdB, 32'd0, 5'd2, 1'b0);

        // Dual writeback to one pending register: channel 1 data wins.
        runIssue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1);
        writeback(2'b11, 5'd7, 32'h1, 5'd7, 32'h2);
        runIssue(5'd7, 5'd0, 2'b01, 5'd0, 1'b0);

        // Reset while in READ with r9 pending.
        runIssue(5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
        applyStimulus(5'd3, 5'd0, 2'b01, 5'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_op_valid", {31'd0, op_valid}, 32'd0);
        checkOutput("mid_rst_rf_read", {30'd0, rf_read}, 32'd0);
        for (int i = 0; i < 32; i++) refPend[i] = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_op_valid", {31'd0, op_valid}, 32'd0);
        tick();
        runIssue(5'd9, 5'd0, 2'b01, 5'd0, 1'b0);

        // Unused pending source must not stall and yields a zero operand.
        runIssue(5'd0, 5'd0, 2'b00, 5'd10, 1'b1);
        runIssue(5'd3, 5'd10, 2'b01, 5'd0, 1'b0);
        writeback(2'b01, 5'd10, 32'h1234, 5'd0, 32'd0);

        // Randomized mix of writebacks and instructions.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                writeback(2'($urandom_range(1, 3)), pickAddr(), $urandom, pickAddr(), $urandom);
            end else begin
                runIssue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                         2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
